// File: rtl/demod_pkg.sv
// Shared types, default LPF coefficients and the output rounding helper
// for the I/Q decimating low-pass filter.
package demod_pkg;

    localparam int COEFF_BITS_DEF = 16;
    localparam int TAPS_DEF       = 8;

    typedef logic signed [COEFF_BITS_DEF-1:0] coeff_t;
    typedef coeff_t [TAPS_DEF-1:0]            coeff_arr_t;

    // Symmetric half-band-ish LPF, Q1.15, taps sum to 32768 (unity DC gain).
    // Element [k] is h[k]; listed here from h[7] down to h[0].
    localparam coeff_arr_t LPF_COEFFS = {
        16'hFE00, 16'h0000, 16'd4608, 16'd12288,
        16'd12288, 16'd4608, 16'h0000, 16'hFE00
    };

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    // Round half up by dropping frac_bits, then clamp to a signed out_bits range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int frac_bits,
                                                     input int out_bits);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_bits - 1));
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/iq_sample_ringbuf.sv
// Dual-lane (I/Q) sample ring buffer: one write port advancing its own
// pointer, one combinational read port addressed by the filter engine.
module iq_sample_ringbuf #(
    parameter int Data_bits = 10,
    parameter int Depth     = 16,
    localparam int AW       = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we,
    input  logic [Data_bits-1:0] i_wr,
    input  logic [Data_bits-1:0] q_wr,
    input  logic [AW-1:0]        rd_addr,
    output logic [Data_bits-1:0] i_rd,
    output logic [Data_bits-1:0] q_rd,
    output logic [AW-1:0]        wr_ptr
);

    // [addr][0] = I word, [addr][1] = Q word
    logic [Depth-1:0][1:0][Data_bits-1:0] mem;

    // Store each accepted pair and advance the pointer; zeroed at reset so
    // history before the first sample reads as silence.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem    <= '0;
            wr_ptr <= '0;
        end else if (we) begin
            mem[wr_ptr] <= {q_wr, i_wr};
            wr_ptr      <= wr_ptr + AW'(1);
        end
    end

    assign i_rd = mem[rd_addr][0];
    assign q_rd = mem[rd_addr][1];

endmodule

// File: rtl/iq_decim_lpf.sv
// I/Q low-pass FIR with decimation: one time-multiplexed MAC per channel
// walks the taps after every Decim-th accepted sample.
module iq_decim_lpf import demod_pkg::*; #(
    parameter int Data_bits  = 10,
    parameter int Coeff_bits = 16,
    parameter int Taps       = 8,
    parameter int Decim      = 4,
    parameter logic [Taps-1:0][Coeff_bits-1:0] Coeffs = LPF_COEFFS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [Data_bits-1:0] I_data_in,
    input  logic [Data_bits-1:0] Q_data_in,
    input  logic                 I_data_valid_i,
    input  logic                 Q_data_valid_i,
    output logic [Data_bits-1:0] I_data_out,
    output logic [Data_bits-1:0] Q_data_out,
    output logic                 iq_valid_o,
    output logic                 mismatch_o,
    output logic                 overrun_o
);

    localparam int AW     = $clog2(2 * Taps);
    localparam int KW     = $clog2(Taps);
    localparam int PW     = (Decim > 1) ? $clog2(Decim) : 1;
    localparam int PROD_W = Data_bits + Coeff_bits;
    localparam int ACC_W  = Data_bits + Coeff_bits + $clog2(Taps);

    logic                     accept, trigger;
    state_t                   state;
    logic [KW-1:0]            k;
    logic [AW-1:0]            base, wr_ptr, rd_addr;
    logic [PW-1:0]            phase;
    logic [Data_bits-1:0]     i_rd, q_rd;
    logic signed [PROD_W-1:0] prod_i, prod_q;
    logic signed [ACC_W-1:0]  acc_i, acc_q;
    logic signed [63:0]       sat_i_wide, sat_q_wide;
    logic [Data_bits-1:0]     res_i, res_q;
    logic [1:0]               vld_pipe;
    logic                     unused_sat;

    assign accept  = I_data_valid_i && Q_data_valid_i;
    assign trigger = accept && (phase == PW'(Decim - 1));
    assign rd_addr = base - AW'(k);

    iq_sample_ringbuf #(
        .Data_bits (Data_bits),
        .Depth     (2 * Taps)
    ) u_ringbuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we      (accept),
        .i_wr    (I_data_in),
        .q_wr    (Q_data_in),
        .rd_addr (rd_addr),
        .i_rd    (i_rd),
        .q_rd    (q_rd),
        .wr_ptr  (wr_ptr)
    );

    // Tap products for the current MAC step and the rounded/saturated sums.
    always_comb begin
        prod_i     = PROD_W'($signed(Coeffs[k])) * PROD_W'($signed(i_rd));
        prod_q     = PROD_W'($signed(Coeffs[k])) * PROD_W'($signed(q_rd));
        sat_i_wide = sat_round(64'(acc_i), Coeff_bits - 1, Data_bits);
        sat_q_wide = sat_round(64'(acc_q), Coeff_bits - 1, Data_bits);
    end

    // Saturation already confines the value to Data_bits; upper bits are sign copies.
    assign unused_sat = ^{sat_i_wide[63:Data_bits], sat_q_wide[63:Data_bits]};

    // Decimation phase and sticky valid-disagreement flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase      <= '0;
            mismatch_o <= 1'b0;
        end else begin
            if (accept)
                phase <= (phase == PW'(Decim - 1)) ? '0 : phase + PW'(1);
            if (I_data_valid_i != Q_data_valid_i)
                mismatch_o <= 1'b1;
        end
    end

    // MAC sequencer: latch the trigger address, walk taps newest-first, then hand off.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            k         <= '0;
            base      <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            overrun_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (trigger) begin
                    state <= ACC;
                    k     <= '0;
                    base  <= wr_ptr;
                    acc_i <= '0;
                    acc_q <= '0;
                end
                ACC: begin
                    acc_i <= acc_i + ACC_W'(prod_i);
                    acc_q <= acc_q + ACC_W'(prod_q);
                    k     <= k + KW'(1);
                    if (k == KW'(Taps - 1))
                        state <= OUT;
                end
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (trigger && state != IDLE)
                overrun_o <= 1'b1;
        end
    end

    // Output stage: capture the rounded result in OUT, present it one cycle later
    // together with the valid pulse; outputs hold between results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe   <= '0;
            res_i      <= '0;
            res_q      <= '0;
            I_data_out <= '0;
            Q_data_out <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], state == OUT};
            if (state == OUT) begin
                res_i <= sat_i_wide[Data_bits-1:0];
                res_q <= sat_q_wide[Data_bits-1:0];
            end
            if (vld_pipe[0]) begin
                I_data_out <= res_i;
                Q_data_out <= res_q;
            end
        end
    end

    assign iq_valid_o = vld_pipe[1];

endmodule

// File: tb/tb_iq_decim_lpf.sv
// Self-checking bench: two instances (Decim=4 and Decim=1) share one stimulus
// stream; a sample-history FIR model predicts every output, flag and pulse time.
module tb_iq_decim_lpf;

    localparam int DW   = 10;
    localparam int TAPS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] i_in = '0, q_in = '0;
    logic          iv = 1'b0, qv = 1'b0;

    logic [DW-1:0] i4, q4, i1, q1;
    logic          v4, v1, m4, m1, o4, o1;

    always #5 clk = ~clk;

    iq_decim_lpf #(.Decim(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .I_data_in(i_in), .Q_data_in(q_in),
        .I_data_valid_i(iv), .Q_data_valid_i(qv),
        .I_data_out(i4), .Q_data_out(q4),
        .iq_valid_o(v4), .mismatch_o(m4), .overrun_o(o4)
    );

    iq_decim_lpf #(.Decim(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .I_data_in(i_in), .Q_data_in(q_in),
        .I_data_valid_i(iv), .Q_data_valid_i(qv),
        .I_data_out(i1), .Q_data_out(q1),
        .iq_valid_o(v1), .mismatch_o(m1), .overrun_o(o1)
    );

    typedef struct { int c; int i; int q; } ev_t;

    int   ncmp = 0, nfail = 0, cyc = 0;
    ev_t  eq0[$], eq1[$];
    int   xi[$], xq[$];
    int   busy[2];
    bit   ovr[2];
    bit   mis;
    int   last_i[2], last_q[2];
    int   H[TAPS] = '{-512, 0, 4608, 12288, 12288, 4608, 0, -512};
    int   sat_pat[8] = '{-512, 511, 511, 511, 511, 511, 511, -512};

    // y[n] = sum h[k]*x[n-k], x before the first sample = 0, round half up, clamp.
    function automatic int fir(int n, bit use_q);
        longint acc = 0;
        longint r;
        for (int kk = 0; kk < TAPS; kk++) begin
            if (n - kk >= 0)
                acc += longint'(H[kk]) * longint'(use_q ? xq[n - kk] : xi[n - kk]);
        end
        r = (acc + 64'sd16384) >>> 15;
        if (r > 511)  r = 511;
        if (r < -512) r = -512;
        return int'(r);
    endfunction

    task automatic model_reset();
        xi.delete(); xq.delete(); eq0.delete(); eq1.delete();
        for (int m = 0; m < 2; m++) begin
            busy[m] = -100; ovr[m] = 1'b0; last_i[m] = 0; last_q[m] = 0;
        end
        mis = 1'b0;
    endtask

    // One clock edge as the spec sees it: accept, trigger, overrun, mismatch.
    task automatic model_edge(bit vi, bit vq, int di, int dq);
        ev_t ev;
        int  n, d;
        if (vi && vq) begin
            xi.push_back(di);
            xq.push_back(dq);
            n = xi.size() - 1;
            for (int m = 0; m < 2; m++) begin
                d = (m == 0) ? 4 : 1;
                if (n % d == d - 1) begin
                    if (cyc <= busy[m]) ovr[m] = 1'b1;
                    else begin
                        ev.c = cyc + TAPS + 2;
                        ev.i = fir(n, 1'b0);
                        ev.q = fir(n, 1'b1);
                        if (m == 0) eq0.push_back(ev); else eq1.push_back(ev);
                        busy[m] = cyc + TAPS + 1;
                    end
                end
            end
        end else if (vi != vq) begin
            mis = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_one(int m, logic v, logic [DW-1:0] io, logic [DW-1:0] qo,
                             logic mo, logic oo);
        bit            ev_v = 1'b0;
        logic [DW-1:0] ei, eqv;
        if (m == 0 && eq0.size() > 0 && eq0[0].c == cyc) begin
            ev_v = 1'b1; last_i[0] = eq0[0].i; last_q[0] = eq0[0].q; void'(eq0.pop_front());
        end
        if (m == 1 && eq1.size() > 0 && eq1[0].c == cyc) begin
            ev_v = 1'b1; last_i[1] = eq1[0].i; last_q[1] = eq1[0].q; void'(eq1.pop_front());
        end
        ei  = DW'(last_i[m]);
        eqv = DW'(last_q[m]);
        chk($sformatf("d%0d_valid", m),    {15'b0, v},  {15'b0, ev_v});
        chk($sformatf("d%0d_i_out", m),    {6'b0, io},  {6'b0, ei});
        chk($sformatf("d%0d_q_out", m),    {6'b0, qo},  {6'b0, eqv});
        chk($sformatf("d%0d_mismatch", m), {15'b0, mo}, {15'b0, mis});
        chk($sformatf("d%0d_overrun", m),  {15'b0, oo}, {15'b0, ovr[m]});
    endtask

    task automatic check_all();
        check_one(0, v4, i4, q4, m4, o4);
        check_one(1, v1, i1, q1, m1, o1);
    endtask

    task automatic step(bit vi, bit vq, int di, int dq);
        iv = vi; qv = vq; i_in = DW'(di); q_in = DW'(dq);
        @(posedge clk);
        cyc++;
        model_edge(vi, vq, di, dq);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic send(int di, int dq, int spacing);
        step(1'b1, 1'b1, di, dq);
        idle(spacing - 1);
    endtask

    task automatic do_reset();
        iv = 1'b0; qv = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // DC: settles to I=100, Q=-100
        repeat (12) send(100, -100, 4);
        idle(12);

        // Impulse: 96, -4, 0, ...
        do_reset();
        send(256, 0, 4);
        repeat (15) send(0, 0, 4);
        idle(12);

        // Saturation high, then the mirrored pattern for the low rail
        do_reset();
        foreach (sat_pat[j]) send(sat_pat[j], 0, 4);
        idle(14);
        do_reset();
        foreach (sat_pat[j]) send(-1 - sat_pat[j], 0, 4);
        idle(14);

        // Single-lane valid: no write, no phase advance, sticky flag
        do_reset();
        send(256, 0, 4);
        send(10, 5, 4);
        step(1'b1, 1'b0, 77, 0);
        idle(3);
        repeat (10) send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512, 4);
        step(1'b0, 1'b1, 0, 33);
        idle(3);
        repeat (4) send(50, -50, 4);
        idle(14);

        // Tight spacing: Decim=1 instance overruns on its 2nd trigger
        do_reset();
        repeat (10) send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512, 3);
        idle(14);

        // Reset while the MAC is mid-way, then replay the impulse
        do_reset();
        send(256, 0, 4);
        send(0, 0, 4);
        send(0, 0, 4);
        step(1'b1, 1'b1, 0, 0);
        idle(3);
        do_reset();
        idle(12);
        send(256, 0, 4);
        repeat (7) send(0, 0, 4);
        idle(14);

        // Random data and spacing
        do_reset();
        repeat (60) send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                         int'($urandom_range(3, 6)));
        idle(14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
